// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the instruction memory from address 0 up to
// LAST_ADDR, buffers fetched words in a 2-entry FIFO and hands them to the
// FPU over a valid/ready interface, counting accepted instructions.
module instr_fetch #(
    parameter logic [3:0] LAST_ADDR = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  PC_addr,
    input  logic [49:0] data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_op,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_ref,
    output logic        busy,
    output logic        done,
    output logic [4:0]  issued
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  pc_r;
    logic [3:0]  pc_nxt_s;
    logic        clear_s;
    logic        push_s;
    logic        pop_s;
    logic [1:0]  sync_r;
    logic [49:0] buf0_r;
    logic [49:0] buf1_r;
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;
    logic [4:0]  issued_r;
    logic [49:0] head_s;

    // Fetch when running and the buffer has room (count before the edge).
    assign push_s = (state_r == RUN) && (count_r < 2'd2);
    assign pop_s  = (count_r != 2'd0) && out_ready;

    // Reset-release synchroniser; the FSM may leave IDLE only once it is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], 1'b1};
        end
    end

    // Next-state and PC update logic of the fetch FSM.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        clear_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && sync_r[1]) begin
                    state_nxt_s = RUN;
                    pc_nxt_s    = 4'd0;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (push_s) begin
                    if (pc_r == LAST_ADDR) begin
                        state_nxt_s = DONE;
                    end else begin
                        pc_nxt_s = pc_r + 4'd1;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start && (count_r == 2'd0)) begin
                    state_nxt_s = RUN;
                    pc_nxt_s    = 4'd0;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pc_nxt_s    = 4'd0;
            end
        endcase
    end

    // State and program counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Two-entry FIFO storage and pointers; push and pop may share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_r   <= 50'd0;
            buf1_r   <= 50'd0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                if (wr_ptr_r) begin
                    buf1_r <= data;
                end else begin
                    buf0_r <= data;
                end
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Accepted-instruction counter, saturating at 31 and cleared on a new run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_r <= 5'd0;
        end else if (clear_s) begin
            issued_r <= 5'd0;
        end else if (pop_s && (issued_r != 5'd31)) begin
            issued_r <= issued_r + 5'd1;
        end else begin
            issued_r <= issued_r;
        end
    end

    // Head entry is masked to zero whenever the buffer is empty.
    assign head_s    = (count_r == 2'd0) ? 50'd0 : (rd_ptr_r ? buf1_r : buf0_r);
    assign out_valid = (count_r != 2'd0);
    assign out_op    = head_s[49:48];
    assign out_a     = head_s[47:32];
    assign out_b     = head_s[31:16];
    assign out_ref   = head_s[15:0];
    assign PC_addr   = pc_r;
    assign busy      = (state_r == RUN) || (count_r != 2'd0);
    assign done      = (state_r == DONE) && (count_r == 2'd0);
    assign issued    = issued_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: two instances (LAST_ADDR 15 and 3)
// share clock and reset; a queue-based scoreboard holds the expected word
// sequence of each run and a negedge monitor checks every handshake.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        st   [2];
    logic [3:0]  pc   [2];
    logic [49:0] dw   [2];
    logic        ov   [2];
    logic        rdy  [2];
    logic [1:0]  op   [2];
    logic [15:0] oa   [2];
    logic [15:0] ob   [2];
    logic [15:0] orf  [2];
    logic        bsy  [2];
    logic        dn   [2];
    logic [4:0]  iss  [2];

    int errs;
    int checks;
    int hs_cnt [2];
    logic        hold_v [2];
    logic [49:0] hold_w [2];
    logic [49:0] exp_q0 [$];
    logic [49:0] exp_q1 [$];
    logic [3:0]  last_of [2];

    // Memory word k as the instruction memory would return it.
    function automatic logic [49:0] word_of(input logic [3:0] k);
        logic [15:0] k16;
        k16 = {12'd0, k};
        return {k[1:0], 16'h3F80 + k16, 16'h4000 + k16, k16};
    endfunction

    assign dw[0] = word_of(pc[0]);
    assign dw[1] = word_of(pc[1]);

    instr_fetch #(.LAST_ADDR(4'd15)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .PC_addr(pc[0]), .data(dw[0]),
        .out_valid(ov[0]), .out_ready(rdy[0]), .out_op(op[0]), .out_a(oa[0]),
        .out_b(ob[0]), .out_ref(orf[0]), .busy(bsy[0]), .done(dn[0]), .issued(iss[0])
    );

    instr_fetch #(.LAST_ADDR(4'd3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .PC_addr(pc[1]), .data(dw[1]),
        .out_valid(ov[1]), .out_ready(rdy[1]), .out_op(op[1]), .out_a(oa[1]),
        .out_b(ob[1]), .out_ref(orf[1]), .busy(bsy[1]), .done(dn[1]), .issued(iss[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: compare each handshake with the expected queue head
    // and check that a stalled output stays stable.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [49:0] w;
            logic [49:0] e;
            w = {op[d], oa[d], ob[d], orf[d]};
            if (!rst_n) begin
                hold_v[d] = 1'b0;
            end else if (ov[d]) begin
                if (hold_v[d]) check(w == hold_w[d], "stall_stable", w, hold_w[d]);
                if (rdy[d]) begin
                    hold_v[d] = 1'b0;
                    hs_cnt[d]++;
                    if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        check(1'b0, "unexpected_word", w, 64'd0);
                    end else begin
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check(w == e, "word_order", w, e);
                    end
                end else begin
                    hold_v[d] = 1'b1;
                    hold_w[d] = w;
                end
            end else begin
                if (hold_v[d]) check(1'b0, "valid_dropped", 64'd0, 64'd1);
                hold_v[d] = 1'b0;
            end
        end
    end

    // Pulse start; the reference model expects words 0..LAST in order.
    task automatic pulse_start(input int d);
        @(posedge clk); #1;
        st[d] = 1'b1;
        for (int k = 0; k <= int'(last_of[d]); k++) begin
            if (d == 0) exp_q0.push_back(word_of(4'(k)));
            else        exp_q1.push_back(word_of(4'(k)));
        end
        @(posedge clk); #1;
        st[d] = 1'b0;
    endtask

    // Drive out_ready (0 hold high, 1 toggle, 2 random) until done, bounded.
    task automatic run_until_done(input int d, input int mode);
        int n;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            if (mode == 1)      rdy[d] = ~rdy[d];
            else if (mode == 2) rdy[d] = 1'($urandom_range(0, 1));
            else                rdy[d] = 1'b1;
            @(negedge clk);
            if (dn[d]) break;
            n++;
            if (n > 300) begin
                check(1'b0, "done_timeout", 64'd0, 64'd1);
                break;
            end
        end
        rdy[d] = 1'b1;
        check(iss[d] == 5'(int'(last_of[d]) + 1), "issued_at_done", iss[d], int'(last_of[d]) + 1);
        check(pc[d] == last_of[d], "pc_at_done", pc[d], last_of[d]);
        check(bsy[d] == 1'b0, "busy_at_done", bsy[d], 0);
        check((d == 0 ? exp_q0.size() : exp_q1.size()) == 0, "all_delivered",
              d == 0 ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        errs = 0; checks = 0;
        last_of[0] = 4'd15; last_of[1] = 4'd3;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; rdy[d] = 1'b1; hs_cnt[d] = 0; hold_v[d] = 1'b0;
        end
        rst_n = 1'b0;
        #12;
        check(ov[0] == 1'b0 && bsy[0] == 1'b0 && dn[0] == 1'b0, "reset_flags", {ov[0], bsy[0], dn[0]}, 0);
        check(iss[0] == 5'd0 && pc[0] == 4'd0, "reset_counters", {iss[0], pc[0]}, 0);
        check({op[0], oa[0], ob[0], orf[0]} == 50'd0, "reset_fields", {op[0], oa[0], ob[0], orf[0]}, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Full run with out_ready high: one fetch cycle latency, 16 back-to-back.
        pulse_start(0);
        @(negedge clk);
        check(ov[0] == 1'b0, "no_valid_before_fetch", ov[0], 0);
        @(posedge clk); #1;
        check(ov[0] == 1'b1 && oa[0] == 16'h3F80, "first_latency", {ov[0], oa[0]}, {1'b1, 16'h3F80});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check(ov[0] == 1'b1, "throughput_valid", ov[0], 1);
        end
        @(negedge clk);
        check(ov[0] == 1'b0 && dn[0] == 1'b1, "done_after_16", {ov[0], dn[0]}, 1);
        check(iss[0] == 5'd16, "issued_16", iss[0], 16);

        // Backpressure: only two fetches, head held, then drain in order.
        rdy[0] = 1'b0;
        pulse_start(0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check(pc[0] == 4'd2, "pc_stall", pc[0], 2);
        check(ov[0] == 1'b1 && oa[0] == 16'h3F80, "head_held", oa[0], 16'h3F80);
        check(iss[0] == 5'd0, "issued_stalled", iss[0], 0);
        run_until_done(0, 0);

        // Toggling out_ready.
        rdy[0] = 1'b0;
        pulse_start(0);
        run_until_done(0, 1);

        // Random out_ready.
        for (int r = 0; r < 3; r++) begin
            rdy[0] = 1'($urandom_range(0, 1));
            pulse_start(0);
            run_until_done(0, 2);
        end

        // Reset mid-run after 5 accepted instructions.
        rdy[0] = 1'b1;
        hs_cnt[0] = 0;
        pulse_start(0);
        n = 0;
        while (hs_cnt[0] < 5 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(iss[0] == 5'd5, "issued_5_before_reset", iss[0], 5);
        rst_n = 1'b0;
        #1;
        check(ov[0] == 1'b0 && bsy[0] == 1'b0 && iss[0] == 5'd0, "reset_midrun", {ov[0], bsy[0], iss[0]}, 0);
        check(oa[0] == 16'h0000 && pc[0] == 4'd0, "reset_midrun_fields", {oa[0], pc[0]}, 0);
        exp_q0.delete();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check(ov[0] == 1'b0 && bsy[0] == 1'b0, "idle_after_reset", {ov[0], bsy[0]}, 0);
        pulse_start(0);
        run_until_done(0, 0);

        // Short program: rerun from DONE, start during RUN ignored.
        rdy[1] = 1'b1;
        pulse_start(1);
        run_until_done(1, 0);
        pulse_start(1);
        @(posedge clk); #1; st[1] = 1'b1;
        @(posedge clk); #1; st[1] = 1'b0;
        run_until_done(1, 0);
        repeat (3) @(negedge clk);
        check(ov[1] == 1'b0 && exp_q1.size() == 0, "no_restart_from_run_start", ov[1], 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 4'd15, meaning the final instruction address fetched in one program run.
REQ-002 SHALL have clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have start  input  1  single-cycle request to run the program from address 0.
REQ-005 SHALL have PC_addr  output  4  address driven to the instruction memory.
REQ-006 SHALL have data  input  50  instruction word returned combinationally for PC_addr.
REQ-007 SHALL have out_valid  output  1  out_* fields hold a valid instruction.
REQ-008 SHALL have out_ready  input  1  FPU accepts the presented instruction.
REQ-009 SHALL have out_op  output  2  instruction bits [49:48], FPU opcode.
REQ-010 SHALL have out_a  output  16  instruction bits [47:32], BFloat16 operand A.
REQ-011 SHALL have out_b  output  16  instruction bits [31:16], BFloat16 operand B.
REQ-012 SHALL have out_ref  output  16  instruction bits [15:0], expected result, passed through unchanged.
REQ-013 SHALL have busy  output  1  high in RUN state or while the buffer is non-empty.
REQ-014 SHALL have done  output  1  high in DONE state once the buffer is empty.
REQ-015 SHALL have issued  output  5  count of instructions accepted by the FPU in the current run.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE, held in registers.
REQ-017 IDLE: start sampled high -> RUN, PC cleared to 0, issued cleared to 0; otherwise stay.
REQ-018 RUN: a fetch SHALL occur on each rising edge where buffer count < 2; the fetch writes data into the buffer and increments PC.
REQ-019 A fetch while PC == LAST_ADDR SHALL transition to DONE and leave PC at LAST_ADDR (no wrap).
REQ-020 DONE: no fetches; start sampled high while buffer empty -> RUN from PC 0 with issued cleared; start while buffer non-empty SHALL be ignored.
REQ-021 start in RUN SHALL be ignored.
REQ-022 PC_addr SHALL equal the PC register at all times (no combinational path from data).
REQ-023 Buffer SHALL be a 2-entry FIFO of 50-bit words; out_* SHALL decode the head entry; out_valid = (count != 0).
REQ-024 Pop SHALL occur on an edge where out_valid and out_ready are both high; issued increments by 1 on each pop, saturating at 31.
REQ-025 Push eligibility SHALL use the count before the edge (no bypass); simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 out_* SHALL remain stable while out_valid high and out_ready low.
REQ-027 First instruction SHALL appear on out_* with out_valid high immediately after the edge following the edge that samples start (one fetch cycle latency).
REQ-028 With out_ready held high, throughput SHALL be one instruction per clock.
REQ-029 out_ready while out_valid low SHALL have no effect.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, PC 0, buffer count 0, out_valid 0, busy 0, done 0, issued 0; out_op/out_a/out_b/out_ref SHALL read 0.
REQ-031 Reset asserted mid-run SHALL discard buffered instructions; after release the block SHALL wait in IDLE for start.
REQ-032 Reset release SHALL be synchronised to clk before state may leave IDLE.

Verification
REQ-033 Memory word k = {2'(k%4), 16'h3F80+k, 16'h4000+k, 16'h0000+k}, out_ready=1, start pulse -> 16 consecutive cycles of out_valid, out_a = 16'h3F80..16'h3F8F in order, then done=1, issued=16.
REQ-034 out_ready=0 after start -> exactly two fetches (PC_addr stops at 2), out_a held at 16'h3F80; out_ready=1 -> remaining words delivered in order, none lost or duplicated.
REQ-035 out_ready toggled 1/0 every cycle -> all 16 instructions issued in order, issued=16, count never exceeds 2.
REQ-036 rst_n pulsed low after 5 instructions issued -> out_valid, busy, issued 0 at once; new start -> restart at word 0.
REQ-037 LAST_ADDR=4'd3, start pulsed again in DONE with buffer empty -> second run delivers words 0..3, issued=4; start pulsed during RUN -> no effect on sequence.
